// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, PC index and writeback request type for the
//                register-file writeback path.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 2**REG_ADDR_W;
   localparam int PC_IDX     = 15;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter; searches from ptr_i upward
//                modulo N and grants the first active request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             grant_vld_o
);

   int               cand;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = 0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         idx = IDX_W'(cand);
         if (!grant_vld_o && req_i[idx]) begin
            grant_vld_o  = 1'b1;
            grant_idx_o  = idx;
            grant_o[idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin sharing of the register-file write port among
//                N_REQ writeback requesters, with PC-redirect split.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = regfile_pkg::REG_DATA_W,
   parameter int ADDR_W = regfile_pkg::REG_ADDR_W,
   parameter int PC_IDX = regfile_pkg::PC_IDX
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic                    flush_i,
   output logic                    we3_o,
   output logic [ADDR_W-1:0]       a3_o,
   output logic [DATA_W-1:0]       wd3_o,
   output logic                    pc_wr_valid_o,
   output logic [DATA_W-1:0]       pc_wr_data_o,
   output logic [2**ADDR_W-1:0]    busy_mask_o
);
   import regfile_pkg::wb_req_t;

   localparam int                IDX_W   = $clog2(N_REQ);
   localparam int                NREG    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  grant;
   logic              grant_vld;
   logic              xfer;
   wb_req_t           sel_req;
   wb_req_t           stage_q, stage_d;
   logic              stage_vld_q, stage_vld_d;
   logic [ADDR_W-1:0] a3_q, a3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic              stage_is_pc;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req_i       (req_valid_i),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_vld_o (grant_vld)
   );

   assign xfer        = grant_vld && rst_n && !flush_i;
   assign req_ready_o = xfer ? grant : '0;

   assign sel_req.addr = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
   assign sel_req.data = req_data_i[grant_idx*DATA_W +: DATA_W];

   always_comb begin
      ptr_d       = ptr_q;
      stage_vld_d = xfer;
      stage_d     = stage_q;
      a3_d        = a3_q;
      wd3_d       = wd3_q;
      if (xfer) begin
         stage_d = sel_req;
         ptr_d   = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
         if (sel_req.addr != PC_ADDR) begin
            a3_d  = sel_req.addr;
            wd3_d = sel_req.data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         stage_vld_q <= 1'b0;
         stage_q     <= '0;
         a3_q        <= '0;
         wd3_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         stage_vld_q <= stage_vld_d;
         stage_q     <= stage_d;
         a3_q        <= a3_d;
         wd3_q       <= wd3_d;
      end
   end

   // The regfile samples on negedge, so flush must mask the staged write
   // combinationally to keep it from landing in the current cycle.
   assign stage_is_pc   = (stage_q.addr == PC_ADDR);
   assign we3_o         = stage_vld_q && !stage_is_pc && !flush_i;
   assign pc_wr_valid_o = stage_vld_q && stage_is_pc && !flush_i;
   assign a3_o          = a3_q;
   assign wd3_o         = wd3_q;
   assign pc_wr_data_o  = stage_q.data;
   assign busy_mask_o   = stage_vld_q ? ({{(NREG-1){1'b0}}, 1'b1} << stage_q.addr) : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed bench for regfile_wb_arbiter with a behavioural
//                arbitration/writeback model and a negedge-sampled regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   req_valid;
   logic [11:0]  req_addr;
   logic [95:0]  req_data;
   logic [2:0]   req_ready;
   logic         flush;
   logic         we3;
   logic [3:0]   a3;
   logic [31:0]  wd3;
   logic         pc_wr_valid;
   logic [31:0]  pc_wr_data;
   logic [15:0]  busy_mask;

   int errors = 0;
   int checks = 0;
   int glog[$];
   bit [31:0] rf [16];

   int         m_ptr  = 0;
   bit         m_vld  = 1'b0;
   logic [3:0] m_addr = '0;
   logic [31:0] m_data = '0;
   logic [3:0] m_a3   = '0;
   logic [31:0] m_wd3 = '0;

   regfile_wb_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid),
      .req_addr_i    (req_addr),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .flush_i       (flush),
      .we3_o         (we3),
      .a3_o          (a3),
      .wd3_o         (wd3),
      .pc_wr_valid_o (pc_wr_valid),
      .pc_wr_data_o  (pc_wr_data),
      .busy_mask_o   (busy_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester that the rules grant right now: scan from the pointer, mod 3.
   function automatic int gidx();
      if (rst_n !== 1'b1 || flush) return -1;
      for (int k = 0; k < 3; k++) begin
         int i;
         i = (m_ptr + k) % 3;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_ready();
      logic [2:0] r;
      int g;
      r = '0;
      g = gidx();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic int onehot_idx(input logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr  <= 0;
         m_vld  <= 1'b0;
         m_addr <= '0;
         m_data <= '0;
         m_a3   <= '0;
         m_wd3  <= '0;
      end else if (gidx() >= 0) begin
         m_vld  <= 1'b1;
         m_addr <= req_addr[gidx()*4 +: 4];
         m_data <= req_data[gidx()*32 +: 32];
         m_ptr  <= (gidx() + 1) % 3;
         if (req_addr[gidx()*4 +: 4] != 4'd15) begin
            m_a3  <= req_addr[gidx()*4 +: 4];
            m_wd3 <= req_data[gidx()*32 +: 32];
         end
      end else begin
         m_vld <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (we3 === 1'b1) rf[a3] <= wd3;
   end

   always @(negedge clk) begin
      chk("ready", {61'd0, req_ready}, {61'd0, exp_ready()});
      chk("we3", {63'd0, we3}, {63'd0, (m_vld && m_addr != 4'd15 && !flush)});
      chk("a3", {60'd0, a3}, {60'd0, m_a3});
      chk("wd3", {32'd0, wd3}, {32'd0, m_wd3});
      chk("pc_valid", {63'd0, pc_wr_valid}, {63'd0, (m_vld && m_addr == 4'd15 && !flush)});
      chk("busy", {48'd0, busy_mask}, {48'd0, (m_vld ? (16'd1 << m_addr) : 16'd0)});
      if (m_vld && m_addr == 4'd15) chk("pc_data", {32'd0, pc_wr_data}, {32'd0, m_data});
      if (!rst_n) chk("pc_data_rst", {32'd0, pc_wr_data}, 64'd0);
      if (|(req_ready & req_valid)) glog.push_back(onehot_idx(req_ready));
   end

   task automatic set_req(input int i, input bit v, input logic [3:0] a, input logic [31:0] d);
      req_valid[i]       = v;
      req_addr[i*4 +: 4] = a;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      flush     = 1'b0;
      repeat (3) next_cycle();
      rst_n = 1'b1;

      // Idle
      repeat (20) next_cycle();
      @(negedge clk);
      chk("idle_ready", {61'd0, req_ready}, 64'd0);
      chk("idle_busy", {48'd0, busy_mask}, 64'd0);
      next_cycle();

      // Single write r3
      set_req(0, 1'b1, 4'd3, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_ready", {61'd0, req_ready}, 64'h1);
      next_cycle();
      set_req(0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("single_we3", {63'd0, we3}, 64'h1);
      chk("single_a3", {60'd0, a3}, 64'h3);
      chk("single_wd3", {32'd0, wd3}, 64'hDEADBEEF);
      chk("single_busy", {48'd0, busy_mask}, 64'h0008);
      next_cycle();
      @(negedge clk);
      chk("rf_r3", {32'd0, rf[3]}, 64'hDEADBEEF);
      next_cycle();

      // PC redirect from requester 1
      set_req(1, 1'b1, 4'd15, 32'h100);
      @(negedge clk);
      chk("pc_ready", {61'd0, req_ready}, 64'h2);
      next_cycle();
      set_req(1, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      chk("pc_we3", {63'd0, we3}, 64'h0);
      chk("pc_pulse", {63'd0, pc_wr_valid}, 64'h1);
      chk("pc_wdata", {32'd0, pc_wr_data}, 64'h100);
      chk("pc_busy", {48'd0, busy_mask}, 64'h8000);
      next_cycle();
      @(negedge clk);
      chk("pc_pulse_end", {63'd0, pc_wr_valid}, 64'h0);
      next_cycle();

      // Requester 2 alone moves the pointer back to 0
      set_req(2, 1'b1, 4'd7, 32'h7777_0007);
      next_cycle();
      set_req(2, 1'b0, 4'd0, 32'd0);
      next_cycle();

      // Burst: all three valid for 6 cycles
      glog.delete();
      set_req(0, 1'b1, 4'd1, 32'hA0A0_0001);
      set_req(1, 1'b1, 4'd2, 32'hB1B1_0002);
      set_req(2, 1'b1, 4'd4, 32'hC2C2_0004);
      repeat (6) next_cycle();
      req_valid = '0;
      chk("burst_len", 64'(glog.size()), 64'd6);
      for (int i = 0; i < 6 && i < glog.size(); i++) begin
         chk($sformatf("burst_grant%0d", i), 64'(glog[i]), 64'(i % 3));
      end
      next_cycle();
      @(negedge clk);
      chk("rf_r4", {32'd0, rf[4]}, 64'hC2C2_0004);
      next_cycle();

      // Flush cancels a staged write to r5
      set_req(0, 1'b1, 4'd5, 32'h0000_0055);
      @(negedge clk);
      chk("flush_pre_ready", {61'd0, req_ready}, 64'h1);
      next_cycle();
      set_req(0, 1'b0, 4'd0, 32'd0);
      set_req(1, 1'b1, 4'd6, 32'h0000_0066);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", {61'd0, req_ready}, 64'h0);
      chk("flush_we3", {63'd0, we3}, 64'h0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_ready", {61'd0, req_ready}, 64'h2);
      next_cycle();
      set_req(1, 1'b0, 4'd0, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rf_r5_untouched", {32'd0, rf[5]}, 64'h0);
      chk("rf_r6", {32'd0, rf[6]}, 64'h66);
      next_cycle();

      // Asynchronous reset in the middle of a burst
      set_req(0, 1'b1, 4'd8, 32'h0000_0008);
      set_req(1, 1'b1, 4'd9, 32'h0000_0009);
      set_req(2, 1'b1, 4'd10, 32'h0000_000A);
      next_cycle();
      next_cycle();
      chk("mid_we3_before", {63'd0, we3}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_we3", {63'd0, we3}, 64'h0);
      chk("rst_busy", {48'd0, busy_mask}, 64'h0);
      chk("rst_ready", {61'd0, req_ready}, 64'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_first_grant", {61'd0, req_ready}, 64'h1);
      next_cycle();
      req_valid = '0;
      repeat (3) next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
